// File: rtl/rmt_input_arbiter_if.sv
// rtl/rmt_input_arbiter_if.sv - AXI-Stream link bundle for the RMT input arbiter
// One instance per stream; master drives payload/tvalid/tlast, slave drives tready.
interface rmt_input_arbiter_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 128
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (
    output tdata, tkeep, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/rmt_input_arbiter.sv
// rtl/rmt_input_arbiter.sv - packet-atomic 2:1 AXIS arbiter, cfg priority with data burst limit
// Optional cfg UDP dst-port check enabled by defining RMT_ARB_CFG_CHECK_EN.
module rmt_input_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int MAX_CFG_BURST        = 4,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                 clk,
  input  logic                 areset,
  rmt_input_arbiter_if.slave   s_data_axis,
  rmt_input_arbiter_if.slave   s_cfg_axis,
  rmt_input_arbiter_if.master  m_axis,
  output logic [CNT_WIDTH-1:0] data_pkt_cnt_o,
  output logic [CNT_WIDTH-1:0] cfg_pkt_cnt_o,
  output logic [CNT_WIDTH-1:0] cfg_drop_cnt_o
);

  localparam int BW = (MAX_CFG_BURST < 1) ? 1 : $clog2(MAX_CFG_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_CFG_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CFG  = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  state_e                         state_q, state_d;
  logic [BW-1:0]                  burst_q, burst_d;
  logic [CNT_WIDTH-1:0]           data_cnt_q, data_cnt_d;
  logic [CNT_WIDTH-1:0]           cfg_cnt_q, cfg_cnt_d;

  logic [C_S_AXIS_DATA_WIDTH-1:0]   sel_tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] sel_tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  sel_tuser;
  logic                             sel_tvalid;
  logic                             sel_tlast;
  logic                             cfg_first;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef RMT_ARB_CFG_CHECK_EN
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                 port_ok;
  // UDP dst port 0xf1f2 lands little-endian in bytes 40..41 of the first beat
  assign port_ok = (s_cfg_axis.tdata[335:320] == 16'hf2f1);
`endif

  // A cfg packet wins when nothing else waits or the burst allowance is not used up
  assign cfg_first = s_cfg_axis.tvalid && (!s_data_axis.tvalid || (burst_q < BURST_MAX));

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    data_cnt_d = data_cnt_q;
    cfg_cnt_d  = cfg_cnt_q;
`ifdef RMT_ARB_CFG_CHECK_EN
    drop_cnt_d = drop_cnt_q;
`endif
    s_data_axis.tready = 1'b0;
    s_cfg_axis.tready  = 1'b0;
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tuser  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!s_data_axis.tvalid) begin
          burst_d = '0;
        end
        if (cfg_first) begin
`ifdef RMT_ARB_CFG_CHECK_EN
          state_d = port_ok ? ST_CFG : ST_DROP;
`else
          state_d = ST_CFG;
`endif
        end else if (s_data_axis.tvalid) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        sel_tdata          = s_data_axis.tdata;
        sel_tkeep          = s_data_axis.tkeep;
        sel_tuser          = s_data_axis.tuser;
        sel_tvalid         = s_data_axis.tvalid;
        sel_tlast          = s_data_axis.tlast;
        s_data_axis.tready = m_axis.tready;
        if (s_data_axis.tvalid && m_axis.tready && s_data_axis.tlast) begin
          state_d    = ST_IDLE;
          burst_d    = '0;
          data_cnt_d = sat_inc(data_cnt_q);
        end
      end

      ST_CFG: begin
        sel_tdata         = s_cfg_axis.tdata;
        sel_tkeep         = s_cfg_axis.tkeep;
        sel_tuser         = s_cfg_axis.tuser;
        sel_tvalid        = s_cfg_axis.tvalid;
        sel_tlast         = s_cfg_axis.tlast;
        s_cfg_axis.tready = m_axis.tready;
        if (s_cfg_axis.tvalid && m_axis.tready && s_cfg_axis.tlast) begin
          state_d   = ST_IDLE;
          burst_d   = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
          cfg_cnt_d = sat_inc(cfg_cnt_q);
        end
      end

`ifdef RMT_ARB_CFG_CHECK_EN
      ST_DROP: begin
        // Sink the rejected packet without touching the master side
        s_cfg_axis.tready = 1'b1;
        if (s_cfg_axis.tvalid && s_cfg_axis.tlast) begin
          state_d    = ST_IDLE;
          drop_cnt_d = sat_inc(drop_cnt_q);
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      burst_q    <= '0;
      data_cnt_q <= '0;
      cfg_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      data_cnt_q <= data_cnt_d;
      cfg_cnt_q  <= cfg_cnt_d;
    end
  end

`ifdef RMT_ARB_CFG_CHECK_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign cfg_drop_cnt_o = drop_cnt_q;
`else
  assign cfg_drop_cnt_o = '0;
`endif

  assign m_axis.tdata  = sel_tdata;
  assign m_axis.tkeep  = sel_tkeep;
  assign m_axis.tuser  = sel_tuser;
  assign m_axis.tvalid = sel_tvalid;
  assign m_axis.tlast  = sel_tlast;

  assign data_pkt_cnt_o = data_cnt_q;
  assign cfg_pkt_cnt_o  = cfg_cnt_q;

endmodule

// File: tb/tb_rmt_input_arbiter.sv
// tb/tb_rmt_input_arbiter.sv - directed bench with packet-level arbitration model and scoreboard
// Honours RMT_ARB_CFG_CHECK_EN to predict cfg drops.
module tb_rmt_input_arbiter;

  localparam int DW = 512;
  localparam int UW = 128;
  localparam int MAXB = 4;

  typedef struct packed {
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic [UW-1:0]   tuser;
    logic            tlast;
  } beat_t;

  typedef struct packed {
    logic        is_cfg;
    logic [7:0]  id;
    logic [3:0]  nb;
    logic [15:0] port;
  } pkt_t;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic rdy_mode = 1'b0;
  logic [31:0] data_cnt, cfg_cnt, drop_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  beat_t data_q[$], cfg_q[$], exp_q[$];
  pkt_t  st_d[$], st_c[$];
  int    ord[$];
  int    m_burst = 0, e_dcnt = 0, e_ccnt = 0, e_drop = 0;

  rmt_input_arbiter_if #(.DATA_W(DW), .USER_W(UW)) d_if ();
  rmt_input_arbiter_if #(.DATA_W(DW), .USER_W(UW)) c_if ();
  rmt_input_arbiter_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

  rmt_input_arbiter #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .MAX_CFG_BURST       (MAXB),
    .CNT_WIDTH           (32)
  ) dut (
    .clk           (clk),
    .areset        (areset),
    .s_data_axis   (d_if),
    .s_cfg_axis    (c_if),
    .m_axis        (m_if),
    .data_pkt_cnt_o(data_cnt),
    .cfg_pkt_cnt_o (cfg_cnt),
    .cfg_drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic beat_t mk_beat(pkt_t p, int i);
    beat_t b;
    for (int w = 0; w < 16; w++) begin
      b.tdata[w*32 +: 32] = {(p.is_cfg ? 8'hC0 : 8'hD0), p.id, 8'(i), 8'(w)};
    end
    if (i == 0) b.tdata[335:320] = p.port;
    b.tkeep = ~64'h0 ^ 64'(i);
    b.tuser = 128'({p.is_cfg, p.id, 8'(i)});
    b.tlast = (i == int'(p.nb) - 1);
    return b;
  endfunction

  function automatic void add_pkt(pkt_t p);
    if (p.is_cfg) st_c.push_back(p);
    else          st_d.push_back(p);
    for (int i = 0; i < int'(p.nb); i++) begin
      if (p.is_cfg) cfg_q.push_back(mk_beat(p, i));
      else          data_q.push_back(mk_beat(p, i));
    end
  endfunction

  function automatic bit cfg_rejected(pkt_t p);
`ifdef RMT_ARB_CFG_CHECK_EN
    return p.port != 16'hf2f1;
`else
    return 1'b0;
`endif
  endfunction

  // Packet-level model: whole packets are granted one at a time from the staged queues
  function automatic void launch();
    pkt_t p;
    bit   take_cfg;
    while (st_d.size() > 0 || st_c.size() > 0) begin
      if (st_d.size() == 0) m_burst = 0;
      take_cfg = (st_c.size() > 0) && (st_d.size() == 0 || m_burst < MAXB);
      if (take_cfg) begin
        p = st_c.pop_front();
        if (cfg_rejected(p)) begin
          e_drop++;
          ord.push_back(2);
        end else begin
          for (int i = 0; i < int'(p.nb); i++) exp_q.push_back(mk_beat(p, i));
          e_ccnt++;
          if (m_burst < MAXB) m_burst++;
          ord.push_back(1);
        end
      end else begin
        p = st_d.pop_front();
        for (int i = 0; i < int'(p.nb); i++) exp_q.push_back(mk_beat(p, i));
        e_dcnt++;
        m_burst = 0;
        ord.push_back(0);
      end
    end
  endfunction

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(string nm);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      #1;
      if (data_q.size() == 0 && cfg_q.size() == 0 && exp_q.size() == 0 && !m_if.tvalid) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected beats left, required 0", nm, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_counts(string nm);
    chk({nm, "_data_cnt"}, DW'(data_cnt), DW'(e_dcnt));
    chk({nm, "_cfg_cnt"},  DW'(cfg_cnt),  DW'(e_ccnt));
    chk({nm, "_drop_cnt"}, DW'(drop_cnt), DW'(e_drop));
  endtask

  initial begin : drv_data
    logic hs;
    beat_t b;
    d_if.tvalid = 1'b0; d_if.tdata = '0; d_if.tkeep = '0; d_if.tuser = '0; d_if.tlast = 1'b0;
    forever begin
      @(negedge clk);
      hs = d_if.tvalid & d_if.tready;
      @(posedge clk);
      #1;
      if (hs && data_q.size() > 0) void'(data_q.pop_front());
      if (data_q.size() > 0) begin
        b = data_q[0];
        d_if.tdata = b.tdata; d_if.tkeep = b.tkeep; d_if.tuser = b.tuser; d_if.tlast = b.tlast;
        d_if.tvalid = 1'b1;
      end else begin
        d_if.tvalid = 1'b0;
      end
    end
  end

  initial begin : drv_cfg
    logic hs;
    beat_t b;
    c_if.tvalid = 1'b0; c_if.tdata = '0; c_if.tkeep = '0; c_if.tuser = '0; c_if.tlast = 1'b0;
    forever begin
      @(negedge clk);
      hs = c_if.tvalid & c_if.tready;
      @(posedge clk);
      #1;
      if (hs && cfg_q.size() > 0) void'(cfg_q.pop_front());
      if (cfg_q.size() > 0) begin
        b = cfg_q[0];
        c_if.tdata = b.tdata; c_if.tkeep = b.tkeep; c_if.tuser = b.tuser; c_if.tlast = b.tlast;
        c_if.tvalid = 1'b1;
      end else begin
        c_if.tvalid = 1'b0;
      end
    end
  end

  initial begin : drv_ready
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rdy_mode ? ~m_if.tready : 1'b1;
    end
  end

  initial begin : compare
    beat_t e;
    logic [DW-1:0] prev_data;
    logic prev_last;
    logic stalled;
    stalled = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (areset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", DW'(m_if.tvalid), DW'(1));
          chk("hold_data", m_if.tdata, prev_data);
          chk("hold_last", DW'(m_if.tlast), DW'(prev_last));
        end
        if (m_if.tvalid && m_if.tready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_unexpected: got tdata %0h, required no beat", m_if.tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_if.tdata, e.tdata);
            chk("beat_keep", DW'(m_if.tkeep), DW'(e.tkeep));
            chk("beat_user", DW'(m_if.tuser), DW'(e.tuser));
            chk("beat_last", DW'(m_if.tlast), DW'(e.tlast));
          end
        end
        chk("single_ready", DW'(d_if.tready & c_if.tready), DW'(0));
        stalled   = m_if.tvalid & ~m_if.tready;
        prev_data = m_if.tdata;
        prev_last = m_if.tlast;
      end
    end
  end

  initial begin : main
    pkt_t p;
    beat_t b;
    logic [7:0] ordv;
    bit found;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_m_tvalid", DW'(m_if.tvalid), DW'(0));
    chk("rst_d_tready", DW'(d_if.tready), DW'(0));
    chk("rst_c_tready", DW'(c_if.tready), DW'(0));
    chk("rst_data_cnt", DW'(data_cnt), DW'(0));
    chk("rst_cfg_cnt", DW'(cfg_cnt), DW'(0));
    sync();
    areset = 1'b0;

    // 1: single 2-beat data packet, one-cycle arbitration bubble
    sync();
    ord.delete();
    p = '{is_cfg: 1'b0, id: 8'd1, nb: 4'd2, port: 16'h0};
    add_pkt(p);
    launch();
    @(negedge clk);
    @(negedge clk);
    chk("t1_bubble", DW'(m_if.tvalid), DW'(0));
    @(negedge clk);
    b = mk_beat(p, 0);
    chk("t1_first_valid", DW'(m_if.tvalid), DW'(1));
    chk("t1_first_data", m_if.tdata, b.tdata);
    wait_drain("t1");
    chk("t1_data_cnt_lit", DW'(data_cnt), DW'(1));
    chk_counts("t1");

    // 2: simultaneous cfg and data from IDLE, cfg first
    sync();
    ord.delete();
    add_pkt('{is_cfg: 1'b0, id: 8'd10, nb: 4'd2, port: 16'h0});
    add_pkt('{is_cfg: 1'b1, id: 8'd11, nb: 4'd3, port: 16'hf2f1});
    launch();
    chk("t2_model_order", DW'({ord[0][1:0], ord[1][1:0]}), DW'(4'b0100));
    wait_drain("t2");
    chk("t2_cfg_cnt_lit", DW'(cfg_cnt), DW'(1));
    chk("t2_data_cnt_lit", DW'(data_cnt), DW'(2));
    chk_counts("t2");

    // 3: six cfg packets against continuously waiting data
    sync();
    ord.delete();
    add_pkt('{is_cfg: 1'b0, id: 8'd20, nb: 4'd2, port: 16'h0});
    add_pkt('{is_cfg: 1'b0, id: 8'd21, nb: 4'd1, port: 16'h0});
    add_pkt('{is_cfg: 1'b1, id: 8'd30, nb: 4'd1, port: 16'hf2f1});
    add_pkt('{is_cfg: 1'b1, id: 8'd31, nb: 4'd2, port: 16'hf2f1});
    add_pkt('{is_cfg: 1'b1, id: 8'd32, nb: 4'd1, port: 16'hf2f1});
    add_pkt('{is_cfg: 1'b1, id: 8'd33, nb: 4'd3, port: 16'hf2f1});
    add_pkt('{is_cfg: 1'b1, id: 8'd34, nb: 4'd1, port: 16'hf2f1});
    add_pkt('{is_cfg: 1'b1, id: 8'd35, nb: 4'd2, port: 16'hf2f1});
    launch();
    ordv = '0;
    for (int i = 0; i < 8; i++) ordv[7-i] = (ord[i] == 1);
    chk("t3_model_order", DW'(ordv), DW'(8'b1111_0110));
    wait_drain("t3");
    chk_counts("t3");

    // 4: toggling downstream ready during a 3-beat cfg packet
    sync();
    ord.delete();
    rdy_mode = 1'b1;
    add_pkt('{is_cfg: 1'b1, id: 8'd40, nb: 4'd3, port: 16'hf2f1});
    add_pkt('{is_cfg: 1'b0, id: 8'd41, nb: 4'd1, port: 16'h0});
    launch();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      #1;
      if (cfg_q.size() == 0) found = 1'b1;
      else chk("t4_data_tready_low", DW'(d_if.tready), DW'(0));
    end
    chk("t4_cfg_done", DW'(found), DW'(1));
    rdy_mode = 1'b0;
    wait_drain("t4");
    chk_counts("t4");

    // 5: cfg packet with wrong UDP port followed by a good one
    sync();
    ord.delete();
    add_pkt('{is_cfg: 1'b1, id: 8'd50, nb: 4'd2, port: 16'h3412});
    add_pkt('{is_cfg: 1'b1, id: 8'd51, nb: 4'd2, port: 16'hf2f1});
    launch();
`ifdef RMT_ARB_CFG_CHECK_EN
    chk("t5_model_order", DW'({ord[0][1:0], ord[1][1:0]}), DW'(4'b1001));
`else
    chk("t5_model_order", DW'({ord[0][1:0], ord[1][1:0]}), DW'(4'b0101));
`endif
    wait_drain("t5");
    chk_counts("t5");

    // 6: reset during beat 2 of a 3-beat packet
    sync();
    ord.delete();
    add_pkt('{is_cfg: 1'b0, id: 8'd60, nb: 4'd3, port: 16'h0});
    launch();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 1) found = 1'b1;
    end
    chk("t6_reach_beat2", DW'(found), DW'(1));
    areset = 1'b1;
    #1;
    chk("t6_rst_tvalid", DW'(m_if.tvalid), DW'(0));
    chk("t6_rst_d_tready", DW'(d_if.tready), DW'(0));
    chk("t6_rst_data_cnt", DW'(data_cnt), DW'(0));
    chk("t6_rst_cfg_cnt", DW'(cfg_cnt), DW'(0));
    chk("t6_rst_drop_cnt", DW'(drop_cnt), DW'(0));
    data_q.delete();
    cfg_q.delete();
    exp_q.delete();
    st_d.delete();
    st_c.delete();
    m_burst = 0; e_dcnt = 0; e_ccnt = 0; e_drop = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    areset = 1'b0;
    sync();
    add_pkt('{is_cfg: 1'b1, id: 8'd61, nb: 4'd2, port: 16'hf2f1});
    launch();
    wait_drain("t6");
    chk("t6_cfg_cnt_lit", DW'(cfg_cnt), DW'(1));
    chk_counts("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
